core_trace_unit: RTL
====================

CORE_TRACE_UNIT -- requirements
Module: core_trace_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC width.
REQ-002 The block SHALL have parameter NUM_BP, default 4, meaning the number of breakpoint comparators (1..16).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the trace FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have parameter TS_W, default 32, meaning the timestamp width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 Port: rst  in  1  synchronous active-high reset.
REQ-008 Port: pc  in  XLEN  core program counter.
REQ-009 Port: state  in  2  core stage; 0 = fetch.
REQ-010 Port: cfg_we  in  1  breakpoint config write strobe.
REQ-011 Port: cfg_idx  in  IW=max(1,clog2(NUM_BP))  breakpoint entry index.
REQ-012 Port: cfg_pc / cfg_en / cfg_halt  in  XLEN/1/1  entry match PC, enable, halt-mode.
REQ-013 Port: resume  in  1  single-cycle pulse releasing halt.
REQ-014 Port: halt  out  1  core stall request.
REQ-015 Port: tr_valid  out  1 / tr_ready  in  1  trace valid/ready handshake.
REQ-016 Port: tr_idx / tr_pc / tr_ts  out  IW/XLEN/TS_W  head-of-FIFO entry fields.
REQ-017 Port: overflow  out  1 / drop_cnt  out  8  sticky loss flag, count of dropped hits.

Function
REQ-018 The timestamp counter SHALL increment every cycle from 0 and wrap modulo 2^TS_W.
REQ-019 A cfg_we write SHALL update entry cfg_idx at the next edge; cfg_idx >= NUM_BP SHALL be ignored.
REQ-020 A hit SHALL be state==0 && armed && halt==0 && an enabled entry with bp_pc==pc.
REQ-021 When several entries match, the lowest index SHALL win, and only one event SHALL be produced per hit.
REQ-022 A config write in the same cycle as a hit SHALL NOT affect that hit; old entry values apply.
REQ-023 The armed flag SHALL clear on a hit and SHALL set in any cycle with state!=0, so one fetch yields at most one hit.
REQ-024 On a hit, the entry {idx, pc, ts of hit cycle} SHALL be pushed into the FIFO; tr_valid SHALL rise at the next edge when the FIFO was empty (latency 1).
REQ-025 tr_valid SHALL equal FIFO not-empty; a pop SHALL occur on tr_valid && tr_ready, and the tr_* outputs SHALL hold stable while tr_valid && !tr_ready.
REQ-026 A push while full with a simultaneous pop SHALL be accepted with no drop.
REQ-027 A push while full without a pop SHALL be dropped, set overflow (sticky until reset), and increment drop_cnt, saturating at 255.
REQ-028 The FSM SHALL have two states, RUN and HALTED.
REQ-029 RUN SHALL go to HALTED at the edge after a hit on an entry with cfg_halt=1, whether or not the trace push was dropped.
REQ-030 HALTED SHALL go to RUN at the edge after a resume pulse.
REQ-031 halt SHALL be 1 exactly in HALTED, and resume SHALL be ignored in RUN.
REQ-032 In HALTED, hit detection SHALL be masked; FIFO draining and config writes SHALL continue.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit used to distinguish full from empty.

Reset
REQ-034 While rst=1 at an edge, halt, tr_valid, overflow and drop_cnt SHALL become 0.
REQ-035 While rst=1 at an edge, tr_idx, tr_pc and tr_ts SHALL become 0.
REQ-036 Reset SHALL empty the FIFO, zero the timestamp, set the FSM to RUN, set armed to 1, and clear all bp_en/bp_halt.
REQ-037 Reset asserted mid-halt or with a non-empty FIFO SHALL discard all state, with no trace output after reset.
REQ-038 Reset SHALL take priority over cfg_we, resume and hits in the same cycle.

Verification
REQ-039 Scenario: program bp0 pc=35, halt=0; drive state=0, pc=35 at ts=100 -> tr_valid=1 next cycle with tr_idx=0, tr_pc=35, tr_ts=100, and halt stays 0.
REQ-040 Scenario: bp1 and bp2 both pc=8 and enabled; fetch pc=8 -> exactly one entry with tr_idx=1.
REQ-041 Scenario: bp0 halt=1, hit -> halt=1 next cycle; a repeat fetch of the same pc while halted produces no entry; resume -> halt=0 next cycle.
REQ-042 Scenario: FIFO_DEPTH=8, tr_ready=0, 10 distinct hits -> 8 entries, overflow=1, drop_cnt=2; drain order matches hit order.
REQ-043 Scenario: FIFO full, hit with tr_ready=1 in the same cycle -> no drop, drop_cnt unchanged, and occupancy stays 8.
REQ-044 Scenario: rst pulsed while halt=1 with 3 queued entries -> halt=0, tr_valid=0, and a post-reset fetch of the old bp pc produces no hit (bp disabled).

Source files
------------

// File: rtl/core_trace_unit.sv
// core_trace_unit: PC breakpoint comparators feeding a timestamped trace FIFO, with halt/resume control.
//   clk, rst                          clock and synchronous active-high reset
//   pc_i, state_i                     core program counter and stage (0 = fetch)
//   cfg_we_i, cfg_idx_i               breakpoint write strobe and entry index
//   cfg_pc_i, cfg_en_i, cfg_halt_i    entry match PC, enable, halt-on-hit
//   resume_i                          single-cycle pulse releasing halt
//   halt_o                            core stall request
//   tr_valid_o, tr_ready_i            trace handshake
//   tr_idx_o, tr_pc_o, tr_ts_o        head-of-FIFO entry fields
//   overflow_o, drop_cnt_o            sticky loss flag and saturating drop count
module core_trace_unit #(
    parameter  int XLEN       = 32,
    parameter  int NUM_BP     = 4,
    parameter  int FIFO_DEPTH = 8,
    parameter  int TS_W       = 32,
    localparam int IW         = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      state_i,
    input  logic            cfg_we_i,
    input  logic [IW-1:0]   cfg_idx_i,
    input  logic [XLEN-1:0] cfg_pc_i,
    input  logic            cfg_en_i,
    input  logic            cfg_halt_i,
    input  logic            resume_i,
    output logic            halt_o,
    output logic            tr_valid_o,
    input  logic            tr_ready_i,
    output logic [IW-1:0]   tr_idx_o,
    output logic [XLEN-1:0] tr_pc_o,
    output logic [TS_W-1:0] tr_ts_o,
    output logic            overflow_o,
    output logic [7:0]      drop_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {RUN, HALTED} fsm_e;

    logic [TS_W-1:0] ts_q;
    logic [XLEN-1:0] bp_pc_q [NUM_BP];
    logic [NUM_BP-1:0] bp_en_q, bp_halt_q;
    logic armed_q, armed_d;
    fsm_e fsm_q;
    logic halt_q;
    logic [IW-1:0] mem_idx [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc [FIFO_DEPTH];
    logic [TS_W-1:0] mem_ts [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic overflow_q, overflow_d;
    logic [7:0] drop_q, drop_d;
    logic match, match_halt;
    logic [IW-1:0] match_idx;
    logic hit, empty, full, pop, push, drop;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        match = 1'b0;
        match_halt = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && bp_pc_q[i] == pc_i) begin
                match = 1'b1;
                match_halt = bp_halt_q[i];
                match_idx = IW'(i);
            end
        end
    end

    assign hit   = state_i == 2'd0 && armed_q && !halt_q && match;
    assign empty = wr_q == rd_q;
    assign full  = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    assign pop   = !empty && tr_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = hit && (!full || pop);
    assign drop  = hit && full && !pop;

    always_comb begin
        armed_d    = hit ? 1'b0 : (state_i != 2'd0 ? 1'b1 : armed_q);
        wr_d       = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d       = pop ? rd_q + (AW+1)'(1) : rd_q;
        overflow_d = overflow_q | drop;
        drop_d     = (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            bp_en_q    <= '0;
            bp_halt_q  <= '0;
            armed_q    <= 1'b1;
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_pc_q[i] <= '0;
        end else begin
            ts_q       <= ts_q + TS_W'(1);
            armed_q    <= armed_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            // Indices with no matching entry simply never select anything.
            for (int i = 0; i < NUM_BP; i++) begin
                if (cfg_we_i && cfg_idx_i == IW'(i)) begin
                    bp_pc_q[i]   <= cfg_pc_i;
                    bp_en_q[i]   <= cfg_en_i;
                    bp_halt_q[i] <= cfg_halt_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_idx[wr_q[AW-1:0]] <= match_idx;
            mem_pc[wr_q[AW-1:0]]  <= pc_i;
            mem_ts[wr_q[AW-1:0]]  <= ts_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= RUN;
            halt_q <= 1'b0;
        end else begin
            unique case (fsm_q)
                RUN: if (hit && match_halt) begin
                    fsm_q  <= HALTED;
                    halt_q <= 1'b1;
                end
                HALTED: if (resume_i) begin
                    fsm_q  <= RUN;
                    halt_q <= 1'b0;
                end
                default: begin
                    fsm_q  <= RUN;
                    halt_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset, so the head fields are forced to zero whenever the FIFO is empty.
    assign halt_o     = halt_q;
    assign tr_valid_o = !empty;
    assign tr_idx_o   = empty ? '0 : mem_idx[rd_q[AW-1:0]];
    assign tr_pc_o    = empty ? '0 : mem_pc[rd_q[AW-1:0]];
    assign tr_ts_o    = empty ? '0 : mem_ts[rd_q[AW-1:0]];
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;
endmodule
